datapath_pipe: RTL

Parametrised, two-stage pipelined successor to the single-cycle datapath: a NUM_REGS × WORD_SIZE register file feeding an eight-operation ALU. Back-to-back instructions are supported through a write-back bypass. It adds an immediate-load operation, a registered result/valid output, a debug read port and an optional status-flag register. It sits under the future control unit, which drives one instruction per cycle on the decoded-control ports.

---
 rtl/datapath_pkg.sv | 21 ++
 rtl/datapath_alu.sv | 54 +++++
 rtl/datapath_pipe.sv | 105 ++++++++++
 3 files changed

// File: rtl/datapath_pkg.sv
// Shared definitions for the pipelined datapath: ALU opcodes and flag bit positions.
// Flag positions apply when DATAPATH_FLAGS_EN is defined.
package datapath_pkg;

  typedef enum logic [2:0] {
    ALU_ADD     = 3'b000,
    ALU_SUB     = 3'b001,
    ALU_AND     = 3'b010,
    ALU_XOR     = 3'b011,
    ALU_OR      = 3'b100,
    ALU_SLT     = 3'b101,
    ALU_SHL     = 3'b110,
    ALU_PASSIMM = 3'b111
  } alu_op_e;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/datapath_alu.sv
// Combinational eight-operation ALU. Carry/overflow are meaningful only for ADD/SUB
// and are driven to 0 for every other opcode.
module datapath_alu
  import datapath_pkg::*;
#(
  parameter int WORD_SIZE = 32
) (
  input  logic [WORD_SIZE-1:0] i_a,
  input  logic [WORD_SIZE-1:0] i_b,
  input  logic [WORD_SIZE-1:0] i_imm,
  input  logic [2:0]           i_op,
  output logic [WORD_SIZE-1:0] o_result,
  output logic                 o_carry,
  output logic                 o_overflow
);

  localparam int SHW = $clog2(WORD_SIZE);
  localparam int MSB = WORD_SIZE - 1;

  alu_op_e            w_op;
  logic [WORD_SIZE:0] w_sum;
  logic [WORD_SIZE:0] w_dif;

  assign w_op  = alu_op_e'(i_op);
  assign w_sum = {1'b0, i_a} + {1'b0, i_b};
  // SUB as A + ~B + 1 so the carry out reads as "no borrow"
  assign w_dif = {1'b0, i_a} + {1'b0, ~i_b} + {{WORD_SIZE{1'b0}}, 1'b1};

  always_comb begin
    o_result   = '0;
    o_carry    = 1'b0;
    o_overflow = 1'b0;
    case (w_op)
      ALU_ADD: begin
        o_result   = w_sum[MSB:0];
        o_carry    = w_sum[WORD_SIZE];
        o_overflow = (i_a[MSB] == i_b[MSB]) && (w_sum[MSB] != i_a[MSB]);
      end
      ALU_SUB: begin
        o_result   = w_dif[MSB:0];
        o_carry    = w_dif[WORD_SIZE];
        o_overflow = (i_a[MSB] != i_b[MSB]) && (w_dif[MSB] != i_a[MSB]);
      end
      ALU_AND:     o_result = i_a & i_b;
      ALU_XOR:     o_result = i_a ^ i_b;
      ALU_OR:      o_result = i_a | i_b;
      ALU_SLT:     o_result[0] = $signed(i_a) < $signed(i_b);
      ALU_SHL:     o_result = i_a << i_b[SHW-1:0];
      ALU_PASSIMM: o_result = i_imm;
      default:     o_result = '0;
    endcase
  end

endmodule

// File: rtl/datapath_pipe.sv
// Two-stage datapath: register file + operand read (issue) then ALU + write-back (EX),
// with an EX->issue bypass. Define DATAPATH_FLAGS_EN to add the {Z,N,C,V} Flags register.
module datapath_pipe
  import datapath_pkg::*;
#(
  parameter  int WORD_SIZE = 32,
  parameter  int NUM_REGS  = 4,
  localparam int ADDR_W    = $clog2(NUM_REGS)
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic                 InValid,
  input  logic [ADDR_W-1:0]    RegReadAddr1,
  input  logic [ADDR_W-1:0]    RegReadAddr2,
  input  logic [ADDR_W-1:0]    RegWriteAddr,
  input  logic                 RegWriteEnable,
  input  logic [2:0]           ALUControl,
  input  logic [WORD_SIZE-1:0] Imm,
  input  logic [ADDR_W-1:0]    DbgReadAddr,
  output logic [WORD_SIZE-1:0] DbgReadData,
  output logic [WORD_SIZE-1:0] Result,
  output logic                 ResultValid
`ifdef DATAPATH_FLAGS_EN
  ,output logic [3:0]          Flags
`endif
);

  logic [NUM_REGS-1:0][WORD_SIZE-1:0] r_regs;
  logic [WORD_SIZE-1:0]               r_ex_a, r_ex_b, r_ex_imm, r_result;
  logic [2:0]                         r_ex_op;
  logic [ADDR_W-1:0]                  r_ex_dst;
  logic                               r_ex_we;
  // [0] = EX stage holds an instruction, [1] = Result holds a fresh value
  logic [1:0]                         r_vld_pipe;

  logic [WORD_SIZE-1:0] w_alu_res, w_opa, w_opb;
  logic                 w_carry, w_ovf, w_wb;

  datapath_alu #(.WORD_SIZE(WORD_SIZE)) u_alu (
    .i_a        (r_ex_a),
    .i_b        (r_ex_b),
    .i_imm      (r_ex_imm),
    .i_op       (r_ex_op),
    .o_result   (w_alu_res),
    .o_carry    (w_carry),
    .o_overflow (w_ovf)
  );

  assign w_wb  = r_vld_pipe[0] && r_ex_we;
  assign w_opa = (w_wb && r_ex_dst == RegReadAddr1) ? w_alu_res : r_regs[RegReadAddr1];
  assign w_opb = (w_wb && r_ex_dst == RegReadAddr2) ? w_alu_res : r_regs[RegReadAddr2];

  // Debug port deliberately sees the committed file only, not the in-flight write
  assign DbgReadData = r_regs[DbgReadAddr];
  assign Result      = r_result;
  assign ResultValid = r_vld_pipe[1];

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_regs     <= '0;
      r_ex_a     <= '0;
      r_ex_b     <= '0;
      r_ex_imm   <= '0;
      r_ex_op    <= '0;
      r_ex_dst   <= '0;
      r_ex_we    <= 1'b0;
      r_result   <= '0;
      r_vld_pipe <= '0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[0], InValid};
      if (InValid) begin
        r_ex_a   <= w_opa;
        r_ex_b   <= w_opb;
        r_ex_imm <= Imm;
        r_ex_op  <= ALUControl;
        r_ex_dst <= RegWriteAddr;
        r_ex_we  <= RegWriteEnable;
      end
      if (w_wb) r_regs[r_ex_dst] <= w_alu_res;
      if (r_vld_pipe[0]) r_result <= w_alu_res;
    end
  end

`ifdef DATAPATH_FLAGS_EN
  logic [3:0] r_flags;

  // Updates on any executed instruction, so SUB without write-back acts as a compare
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_flags <= '0;
    end else if (r_vld_pipe[0]) begin
      r_flags[FLAG_Z] <= (w_alu_res == '0);
      r_flags[FLAG_N] <= w_alu_res[WORD_SIZE-1];
      r_flags[FLAG_C] <= w_carry;
      r_flags[FLAG_V] <= w_ovf;
    end
  end

  assign Flags = r_flags;
`else
  logic w_unused_flags;
  assign w_unused_flags = w_carry ^ w_ovf;
`endif

endmodule
